rgb_theme_decoder: RTL and testbench

Inverse of the panel's theme colouring stage. Accepts a streamed, themed RGB pixel frame and learns the active theme from each frame's colour statistics. Recovers the 1-bit character/background pixel plane for the next frame. Sits on the frame-readback / self-test path, feeding the character-plane checker and reporting the detected 3-bit theme code.

---
 rtl/theme_pkg.sv | 61 ++++++
 rtl/rgb_palette_match.sv | 32 +++
 rtl/rgb_theme_decoder.sv | 162 ++++++++++++++++
 tb/tb_rgb_theme_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/theme_pkg.sv
// Shared theme/palette definitions for the panel
// colouring stage and its readback decoder.
package theme_pkg;

  localparam int NPAL = 7;

  typedef logic [2:0] pal_idx_t;
  typedef logic [2:0] theme_t;

  localparam pal_idx_t PAL_BLACK   = 3'd0;
  localparam pal_idx_t PAL_WHITE   = 3'd1;
  localparam pal_idx_t PAL_DKGREEN = 3'd2;
  localparam pal_idx_t PAL_GRAY    = 3'd3;
  localparam pal_idx_t PAL_GREEN   = 3'd4;
  localparam pal_idx_t PAL_NAVY    = 3'd5;
  localparam pal_idx_t PAL_PINK    = 3'd6;

  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_DKGREEN = 24'h2A572A;
  localparam logic [23:0] RGB_GRAY    = 24'hAAAAAA;
  localparam logic [23:0] RGB_GREEN   = 24'h00AA00;
  localparam logic [23:0] RGB_NAVY    = 24'h00003C;
  localparam logic [23:0] RGB_PINK    = 24'hF470F6;

  localparam theme_t TH_WOK  = 3'd0;
  localparam theme_t TH_KOW  = 3'd1;
  localparam theme_t TH_KOG  = 3'd2;
  localparam theme_t TH_KOGY = 3'd3;
  localparam theme_t TH_GOK  = 3'd4;
  localparam theme_t TH_WOB  = 3'd5;
  localparam theme_t TH_GYOK = 3'd6;
  localparam theme_t TH_POK  = 3'd7;

  typedef struct packed {
    pal_idx_t fg;
    pal_idx_t bg;
  } pair_t;

  typedef enum logic {
    ST_RUN,
    ST_DECIDE
  } state_t;

  function automatic pair_t theme_pair(theme_t t);
    pair_t p;
    p = '0;
    unique case (t)
      TH_WOK:  p = '{PAL_WHITE, PAL_BLACK};
      TH_KOW:  p = '{PAL_BLACK, PAL_WHITE};
      TH_KOG:  p = '{PAL_BLACK, PAL_DKGREEN};
      TH_KOGY: p = '{PAL_BLACK, PAL_GRAY};
      TH_GOK:  p = '{PAL_GREEN, PAL_BLACK};
      TH_WOB:  p = '{PAL_WHITE, PAL_NAVY};
      TH_GYOK: p = '{PAL_GRAY, PAL_BLACK};
      TH_POK:  p = '{PAL_PINK, PAL_BLACK};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rgb_palette_match.sv
// Combinational RGB to palette index lookup.
// Colours outside the palette report hit=0.
module rgb_palette_match
  import theme_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       hit,
  output pal_idx_t   idx
);

  logic [23:0] rgb;

  assign rgb = {r, g, b};

  always_comb begin
    hit = 1'b1;
    idx = PAL_BLACK;
    unique case (1'b1)
      (rgb == RGB_BLACK):   idx = PAL_BLACK;
      (rgb == RGB_WHITE):   idx = PAL_WHITE;
      (rgb == RGB_DKGREEN): idx = PAL_DKGREEN;
      (rgb == RGB_GRAY):    idx = PAL_GRAY;
      (rgb == RGB_GREEN):   idx = PAL_GREEN;
      (rgb == RGB_NAVY):    idx = PAL_NAVY;
      (rgb == RGB_PINK):    idx = PAL_PINK;
      default:              hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/rgb_theme_decoder.sv
// Recovers the character plane from a themed RGB
// stream and learns the theme from colour counts.
module rgb_theme_decoder
  import theme_pkg::*;
#(
  parameter int CNT_W = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_sof,
  input  logic       in_eof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pxo,
  output logic       px_unk,
  output logic       out_sof,
  output logic       out_eof,
  output logic [2:0] theme,
  output logic       locked
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state, nstate;
  logic acc, decide;
  logic pm_hit;
  pal_idx_t pm_idx;
  logic [CNT_W-1:0] cnt [NPAL];

  rgb_palette_match u_match (
    .r   (in_r),
    .g   (in_g),
    .b   (in_b),
    .hit (pm_hit),
    .idx (pm_idx)
  );

  assign acc = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_RUN:    if (acc && in_eof) nstate = ST_DECIDE;
      ST_DECIDE: nstate = ST_RUN;
    endcase
  end

  always_comb begin
    decide   = (state == ST_DECIDE);
    in_ready = (state == ST_RUN) &&
               (!out_valid || out_ready);
  end

  // sof restarts the statistics, so a frame lost
  // its eof never pollutes the next decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPAL; i++) cnt[i] <= '0;
    end else if (decide) begin
      for (int i = 0; i < NPAL; i++) cnt[i] <= '0;
    end else if (acc) begin
      for (int i = 0; i < NPAL; i++) begin
        if (in_sof)
          cnt[i] <= (pm_hit && pm_idx == 3'(i))
                    ? ONE : '0;
        else if (pm_hit && pm_idx == 3'(i) &&
                 cnt[i] != '1)
          cnt[i] <= cnt[i] + ONE;
      end
    end
  end

  logic [CNT_W-1:0] bg_c, fg_c;
  pal_idx_t bg_i, fg_i;
  logic fg_ok;

  // strict compares keep the lowest index on ties
  always_comb begin
    bg_c = cnt[0];
    bg_i = PAL_BLACK;
    for (int i = 1; i < NPAL; i++) begin
      if (cnt[i] > bg_c) begin
        bg_c = cnt[i];
        bg_i = 3'(i);
      end
    end
    fg_c = '0;
    fg_i = PAL_BLACK;
    for (int i = 0; i < NPAL; i++) begin
      if (3'(i) != bg_i && cnt[i] > fg_c) begin
        fg_c = cnt[i];
        fg_i = 3'(i);
      end
    end
    fg_ok = (fg_c != '0);
  end

  pair_t want;
  theme_t hit_t;
  logic pair_ok;

  always_comb begin
    want.fg = fg_i;
    want.bg = bg_i;
    hit_t   = TH_WOK;
    pair_ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (theme_pair(3'(t)) == want) begin
        hit_t   = 3'(t);
        pair_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      theme  <= TH_WOK;
      locked <= 1'b0;
    end else if (decide && fg_ok && pair_ok) begin
      theme  <= hit_t;
      locked <= 1'b1;
    end
  end

  pair_t cur;
  logic is_fg, is_bg;

  always_comb begin
    cur   = theme_pair(theme);
    is_fg = pm_hit && (pm_idx == cur.fg);
    is_bg = pm_hit && (pm_idx == cur.bg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pxo       <= 1'b0;
      px_unk    <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      pxo       <= is_fg;
      px_unk    <= !(is_fg || is_bg);
      out_sof   <= in_sof;
      out_eof   <= in_eof;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgb_theme_decoder.sv
// Self-checking bench: directed theme frames plus
// random frames against a counting reference model.
module tb_rgb_theme_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic       in_sof = 1'b0, in_eof = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       pxo, px_unk, out_sof, out_eof;
  logic [2:0] theme;
  logic       locked;

  rgb_theme_decoder #(.CNT_W(19)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pxo       (pxo),
    .px_unk    (px_unk),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .theme     (theme),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // index 7 is an off-palette colour
  int pal_r [8] = '{0, 255, 42, 170, 0, 0, 244, 1};
  int pal_g [8] = '{0, 255, 87, 170, 170, 0, 112, 2};
  int pal_b [8] = '{0, 255, 42, 170, 0, 60, 246, 3};
  int tfg [8] = '{1, 0, 0, 0, 4, 1, 3, 6};
  int tbg [8] = '{0, 1, 2, 3, 0, 5, 0, 0};

  int m_cnt [7];
  int m_theme;
  bit m_locked;
  bit m_pend;
  logic [3:0] exp_q [$];
  bit l_acc, l_pop;
  int l_r, l_g, l_b;
  bit l_sof, l_eof;
  bit rnd_bp = 1'b0;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               n, a, e, $time);
    end
  endtask

  function automatic int lookup(int r, int g, int b);
    for (int i = 0; i < 7; i++)
      if (pal_r[i] == r && pal_g[i] == g &&
          pal_b[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_theme = 0;
    m_locked = 0;
    m_pend = 0;
    exp_q.delete();
    l_acc = 0;
    l_pop = 0;
  endtask

  task automatic model_decide();
    int bg, fg;
    bg = 0;
    fg = -1;
    for (int i = 1; i < 7; i++)
      if (m_cnt[i] > m_cnt[bg]) bg = i;
    for (int i = 0; i < 7; i++)
      if (i != bg && m_cnt[i] > 0 &&
          (fg < 0 || m_cnt[i] > m_cnt[fg])) fg = i;
    if (fg >= 0)
      for (int t = 0; t < 8; t++)
        if (tfg[t] == fg && tbg[t] == bg) begin
          m_theme = t;
          m_locked = 1;
        end
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  function automatic bit exp_ready();
    return !m_pend &&
           (exp_q.size() == 0 || out_ready);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid),
          int'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk("out_fields",
            int'({pxo, px_unk, out_sof, out_eof}),
            int'(exp_q[0]));
      chk("theme", int'(theme), m_theme);
      chk("locked", int'(locked), int'(m_locked));
      chk("in_ready", int'(in_ready),
          int'(exp_ready()));
      l_acc = in_valid && exp_ready();
      l_pop = (exp_q.size() != 0) && out_ready;
      l_r = int'(in_r);
      l_g = int'(in_g);
      l_b = int'(in_b);
      l_sof = in_sof;
      l_eof = in_eof;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_pend) begin
        model_decide();
        m_pend = 0;
      end
      if (l_pop) void'(exp_q.pop_front());
      if (l_acc) begin
        int c;
        bit f, u;
        c = lookup(l_r, l_g, l_b);
        f = (c == tfg[m_theme]);
        u = !f && (c != tbg[m_theme]);
        exp_q.push_back({f, u, l_sof, l_eof});
        if (l_sof) foreach (m_cnt[i]) m_cnt[i] = 0;
        if (c >= 0 && m_cnt[c] < (1 << 19) - 1)
          m_cnt[c]++;
        if (l_eof) m_pend = 1;
      end
      l_acc = 0;
      l_pop = 0;
    end
  end

  task automatic send(int col, bit sof, bit eof);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_r = 8'(pal_r[col]);
    in_g = 8'(pal_g[col]);
    in_b = 8'(pal_b[col]);
    in_sof = sof;
    in_eof = eof;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_eof = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(int nbg, int bg, int nfg,
                       int fg, int nmiss);
    int tot;
    tot = nbg + nmiss + nfg;
    for (int k = 0; k < tot; k++)
      send(k < nbg ? bg :
           k < nbg + nmiss ? 7 : fg,
           k == 0, k == tot - 1);
    idle(2);
  endtask

  task automatic lit_theme(string n, int t, int l);
    chk({n, "_theme"}, int'(theme), t);
    chk({n, "_locked"}, int'(locked), l);
  endtask

  task automatic lit_out(string n, int p, int u);
    @(negedge clk);
    chk({n, "_valid"}, int'(out_valid), 1);
    chk({n, "_pxo"}, int'(pxo), p);
    chk({n, "_unk"}, int'(px_unk), u);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_bp)
        out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_theme", int'(theme), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    frame(7, 0, 3, 1, 0);
    lit_theme("wok", 0, 1);
    send(1, 1, 0);
    lit_out("white_fg", 1, 0);
    send(0, 0, 0);
    lit_out("black_bg", 0, 0);
    idle(1);

    frame(7, 1, 3, 0, 0);
    lit_theme("kow", 1, 1);
    frame(6, 3, 4, 0, 0);
    lit_theme("kogy", 3, 1);
    frame(6, 0, 4, 3, 0);
    lit_theme("gyok", 6, 1);
    frame(10, 0, 0, 0, 0);
    lit_theme("allblack", 6, 1);
    frame(5, 0, 5, 1, 0);
    lit_theme("tie", 0, 1);

    send(7, 1, 0);
    lit_out("miss", 0, 1);
    idle(1);
    frame(7, 1, 3, 0, 0);
    frame(4, 0, 3, 1, 5);
    lit_theme("miss_frame", 0, 1);

    out_ready = 1'b0;
    send(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_pxo", int'(pxo), 1);
      chk("bp_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(1);

    frame(6, 3, 4, 0, 0);
    for (int i = 0; i < 5; i++) send(1, i == 0, 0);
    frame(7, 0, 3, 1, 0);
    lit_theme("sof_restart", 0, 1);

    frame(6, 3, 4, 0, 0);
    send(0, 1, 0);
    send(3, 0, 0);
    rst_n = 1'b0;
    #2;
    lit_theme("midrst", 0, 0);
    chk("midrst_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    rnd_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int t, len, sel, col;
      bit s, e;
      t = $urandom_range(0, 7);
      len = $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        sel = $urandom_range(0, 99);
        if (sel < 55)      col = tbg[t];
        else if (sel < 85) col = tfg[t];
        else if (sel < 93) col = $urandom_range(0, 6);
        else               col = 7;
        s = (k == 0) && ($urandom_range(0, 7) != 0);
        e = (k == len - 1) &&
            ($urandom_range(0, 7) != 0);
        send(col, s, e);
        if ($urandom_range(0, 3) == 0) idle(0);
      end
    end
    rnd_bp = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
